dmem_rmw_controller: RTL

Parametrised data-memory controller between the RISCV core load/store stage and the single-port data DRAM. It accepts one request at a time over a valid/ready handshake and handles byte-lane placement at any aligned offset. Sub-word stores use a read-modify-write sequence because the DRAM has no byte enables. The controller also supports a configurable DRAM read latency and reports misaligned or illegal accesses with an error response.

---
 rtl/dmem_rmw_controller.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_rmw_controller.sv
// -----------------------------------------------------------------------------
// dmem_rmw_controller
// Data-memory controller between the core load/store stage and a single-port
// DRAM without byte enables. One request is serviced at a time. Sub-word
// stores are done as read-modify-write, loads extract and sign/zero-extend the
// addressed lane, and misaligned or illegal accesses get an error response
// without touching the DRAM.
//
// Ports
//   clk, nrst         clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = store, 0 = load
//   req_funct3        RISC-V funct3 encoding of access size / signedness
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   rsp_valid         one-cycle response pulse
//   rsp_rdata         load result (0 for stores and errors)
//   rsp_err           misaligned / illegal access, qualifies rsp_valid
//   dram_re/dram_we   DRAM read / write enables (never both high)
//   dram_address      DRAM word address of the latched request
//   dram_datain       word written to DRAM (0 outside WRITE)
//   dram_rdata        DRAM read word, valid DRAM_LAT cycles after dram_re
// -----------------------------------------------------------------------------
module dmem_rmw_controller #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 11,
    parameter int DRAM_LAT = 1,
    localparam int OFF_W   = $clog2(DATA_W / 8)
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    dram_re,
    output logic                    dram_we,
    output logic [ADDR_W-OFF_W-1:0] dram_address,
    output logic [DATA_W-1:0]       dram_datain,
    input  logic [DATA_W-1:0]       dram_rdata
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(DRAM_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Shift the addressed lane down and extend it to the full word.
    function automatic logic [DATA_W-1:0] lane_extract(
        input logic [DATA_W-1:0] word,
        input logic [2:0]        f3,
        input logic [OFF_W-1:0]  off
    );
        logic [DATA_W-1:0] shifted;
        logic [DATA_W-1:0] res;
        logic              sign;
        int                nbits;
        shifted = word >> {off, 3'b000};
        nbits   = int'(32'd8 << f3[1:0]);
        nbits   = (nbits > DATA_W) ? DATA_W : nbits;
        sign    = ~f3[2] & shifted[nbits-1];
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = (i < nbits) ? shifted[i] : sign;
        end
        return res;
    endfunction

    // Replace lanes off..off+size-1 of the old word with the low store bytes.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wd,
        input logic [2:0]        f3,
        input logic [OFF_W-1:0]  off
    );
        logic [DATA_W-1:0] res;
        int                size;
        int                base;
        size = int'(32'd1 << f3[1:0]);
        base = int'(off);
        for (int b = 0; b < NBYTES; b++) begin
            if ((b >= base) && (b < base + size)) begin
                res[8*b +: 8] = wd[8*(b-base) +: 8];
            end else begin
                res[8*b +: 8] = old[8*b +: 8];
            end
        end
        return res;
    endfunction

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                we_r;
    logic [2:0]          funct3_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                latch_s;

    logic                dram_re_r, dram_re_s;
    logic                dram_we_r, dram_we_s;
    logic [DATA_W-1:0]   dram_datain_r, dram_datain_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic                rsp_err_r, rsp_err_s;
    logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;

    logic [3:0]          size_s;
    logic                misaligned_s;
    logic                illegal_s;
    logic                full_s;
    logic [OFF_W-1:0]    off_r_s;

    // Legality of the raw request; only consulted while IDLE.
    assign size_s       = 4'd1 << req_funct3[1:0];
    assign misaligned_s = (({{(4-OFF_W){1'b0}}, req_addr[OFF_W-1:0]} & (size_s - 4'd1)) != 4'd0);
    assign illegal_s    = ((DATA_W == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)))
                        || (!req_we && (req_funct3 == 3'b111))
                        || (req_we && req_funct3[2]);
    assign full_s       = req_we && (size_s == 4'(NBYTES));
    assign off_r_s      = addr_r[OFF_W-1:0];

    assign req_ready    = (state_r == ST_IDLE);
    assign dram_address = addr_r[ADDR_W-1:OFF_W];
    assign dram_re      = dram_re_r;
    assign dram_we      = dram_we_r;
    assign dram_datain  = dram_datain_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_err      = rsp_err_r;
    assign rsp_rdata    = rsp_rdata_r;

    // Next state plus next values of the registered outputs; each output is
    // computed for the state being entered so it is high during that state.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        latch_s       = 1'b0;
        dram_re_s     = 1'b0;
        dram_we_s     = 1'b0;
        dram_datain_s = '0;
        rsp_valid_s   = 1'b0;
        rsp_err_s     = 1'b0;
        rsp_rdata_s   = '0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    latch_s = 1'b1;
                    if (illegal_s || misaligned_s) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b1;
                    end else if (full_s) begin
                        state_s       = ST_WRITE;
                        dram_we_s     = 1'b1;
                        dram_datain_s = req_wdata;
                    end else begin
                        state_s   = ST_READ;
                        dram_re_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_WAIT;
                cnt_s   = CNT_W'(DRAM_LAT - 1);
            end
            ST_WAIT: begin
                // Counter at zero marks the cycle in which dram_rdata is valid.
                if (cnt_r == '0) begin
                    if (we_r) begin
                        state_s       = ST_WRITE;
                        dram_we_s     = 1'b1;
                        dram_datain_s = lane_merge(dram_rdata, wdata_r, funct3_r, off_r_s);
                    end else begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_rdata_s = lane_extract(dram_rdata, funct3_r, off_r_s);
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_WRITE: begin
                state_s     = ST_RESP;
                rsp_valid_s = 1'b1;
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, request latch and registered outputs; reset aborts everything.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            we_r          <= 1'b0;
            funct3_r      <= 3'b000;
            addr_r        <= '0;
            wdata_r       <= '0;
            dram_re_r     <= 1'b0;
            dram_we_r     <= 1'b0;
            dram_datain_r <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_err_r     <= 1'b0;
            rsp_rdata_r   <= '0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            if (latch_s) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
            end
            dram_re_r     <= dram_re_s;
            dram_we_r     <= dram_we_s;
            dram_datain_r <= dram_datain_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_err_r     <= rsp_err_s;
            rsp_rdata_r   <= rsp_rdata_s;
        end
    end

endmodule
